ram_1p_req_ctrl: RTL

- Request front-end and response buffer for the single-port RAM wrapper (with optional ECC/parity and input/output pipelines).
- Turns a valid/ready request stream into single-cycle RAM strobes (req/write/addr/wdata/wmask).
- Captures rvalid/rdata/rerror into a response FIFO so the consumer can apply backpressure.
- Credit-based issue: a read is issued only when its response is guaranteed a FIFO slot, so no response is ever dropped.

---
 rtl/ram_1p_req_ctrl_pkg.sv | 14 +
 rtl/ram_1p_rsp_fifo.sv | 60 ++++++
 rtl/ram_1p_req_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/ram_1p_req_ctrl_pkg.sv
// Shared constants for the single-port RAM request front-end and its response FIFO.
package ram_1p_req_ctrl_pkg;

   localparam int ERR_CORR_IDX   = 0;
   localparam int ERR_UNCORR_IDX = 1;
   localparam int ErrCntW        = 16;
   localparam int MaxRspDepth    = 16;

   // Saturating increment used by the error counters.
   function automatic logic [ErrCntW-1:0] sat_inc(input logic [ErrCntW-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/ram_1p_rsp_fifo.sv
// Synchronous response FIFO with flush and occupancy count; any depth 1..16,
// pointers wrap modulo Depth. Output is driven from stored entries only.
module ram_1p_rsp_fifo #(
   parameter int Width = 34,
   parameter int Depth = 4,
   localparam int CntW = $clog2(Depth + 1),
   localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [Width-1:0] wdata_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [Width-1:0] rdata_o,
   output logic [CntW-1:0]  count_o
);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
   logic [CntW-1:0]  cnt_q;
   logic             push, pop;

   function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   assign valid_o = (cnt_q != '0);
   // A flush wins over both push and pop in the same cycle.
   assign push    = push_i & ~flush_i;
   assign pop     = valid_o & ready_i & ~flush_i;
   assign rdata_o = valid_o ? mem_q[rd_ptr_q] : '0;
   assign count_o = cnt_q;

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= wdata_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else if (flush_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
         if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/ram_1p_req_ctrl.sv
// Request front-end and credit-managed response buffer for the single-port RAM wrapper.
// Optional error counters enabled by defining RAM_1P_REQ_CTRL_ERR_CNT_EN.
module ram_1p_req_ctrl
   import ram_1p_req_ctrl_pkg::*;
#(
   parameter int Aw       = 9,
   parameter int Width    = 32,
   parameter int RspDepth = 4,
   localparam int CntW    = $clog2(RspDepth + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic             req_write_i,
   input  logic [Aw-1:0]    req_addr_i,
   input  logic [Width-1:0] req_wdata_i,
   input  logic [Width-1:0] req_wmask_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [Width-1:0] rsp_rdata_o,
   output logic [1:0]       rsp_rerror_o,
   output logic             ram_req_o,
   output logic             ram_write_o,
   output logic [Aw-1:0]    ram_addr_o,
   output logic [Width-1:0] ram_wdata_o,
   output logic [Width-1:0] ram_wmask_o,
   input  logic             ram_rvalid_i,
   input  logic [Width-1:0] ram_rdata_i,
   input  logic [1:0]       ram_rerror_i,
   output logic [CntW-1:0]  outstanding_o,
   output logic             proto_err_o
`ifdef RAM_1P_REQ_CTRL_ERR_CNT_EN
   ,
   output logic [ErrCntW-1:0] corr_cnt_o,
   output logic [ErrCntW-1:0] uncorr_cnt_o
`endif
);

   if (RspDepth < 1 || RspDepth > MaxRspDepth) begin : g_bad_depth
      $error("RspDepth must be within 1..16");
   end

   logic [CntW-1:0]  out_q, out_d, disc_q, disc_d, fifo_cnt;
   logic [CntW+1:0]  credit_sum;
   logic             credit_ok, rd_issue, ret_discard, ret_count, ret_orphan, push;
   logic [Width+1:0] fifo_rdata;

   // Handshake: a transfer happens on a cycle where valid and ready are both high;
   // ready never depends on valid, and a producer holds its payload until accepted.
   assign credit_sum  = (CntW+2)'(out_q) + (CntW+2)'(disc_q) + (CntW+2)'(fifo_cnt);
   assign credit_ok   = credit_sum < (CntW+2)'(RspDepth);
   assign req_ready_o = credit_ok & ~flush_i;

   assign ram_req_o   = req_valid_i & req_ready_o;
   assign ram_write_o = req_write_i;
   assign ram_addr_o  = req_addr_i;
   assign ram_wdata_o = req_wdata_i;
   assign ram_wmask_o = req_wmask_i;

   assign rd_issue    = ram_req_o & ~req_write_i;
   // Returns are attributed to discarded reads first: those were issued earliest.
   assign ret_discard = ram_rvalid_i & (disc_q != '0);
   assign ret_count   = ram_rvalid_i & (disc_q == '0) & (out_q != '0);
   assign ret_orphan  = ram_rvalid_i & (disc_q == '0) & (out_q == '0);
   assign push        = ret_count & ~flush_i;

   always_comb begin
      out_d  = out_q;
      disc_d = disc_q;
      if (flush_i) begin
         out_d  = '0;
         disc_d = disc_q + out_q - CntW'(ret_count) - CntW'(ret_discard);
      end else begin
         out_d  = out_q + CntW'(rd_issue) - CntW'(ret_count);
         disc_d = disc_q - CntW'(ret_discard);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_q       <= '0;
         disc_q      <= '0;
         proto_err_o <= 1'b0;
      end else begin
         out_q       <= out_d;
         disc_q      <= disc_d;
         proto_err_o <= proto_err_o | ret_orphan;
      end
   end

   assign outstanding_o = out_q;

   ram_1p_rsp_fifo #(
      .Width (Width + 2),
      .Depth (RspDepth)
   ) u_rsp_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .push_i  (push),
      .wdata_i ({ram_rerror_i, ram_rdata_i}),
      .valid_o (rsp_valid_o),
      .ready_i (rsp_ready_i),
      .rdata_o (fifo_rdata),
      .count_o (fifo_cnt)
   );

   assign rsp_rdata_o  = fifo_rdata[Width-1:0];
   assign rsp_rerror_o = fifo_rdata[Width+1:Width];

`ifdef RAM_1P_REQ_CTRL_ERR_CNT_EN
   // Only responses that actually enter the FIFO are counted.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         corr_cnt_o   <= '0;
         uncorr_cnt_o <= '0;
      end else if (push) begin
         if (ram_rerror_i[ERR_CORR_IDX])   corr_cnt_o   <= sat_inc(corr_cnt_o);
         if (ram_rerror_i[ERR_UNCORR_IDX]) uncorr_cnt_o <= sat_inc(uncorr_cnt_o);
      end
   end
`endif

endmodule
